// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for a multicycle MIPS datapath. Sequences one shared ALU and
// one shared memory over 3-5 cycles per instruction. Adds a memory-ready
// handshake, illegal-instruction trapping and a retired-instruction counter.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   opcode, Funct   : instruction fields from the instruction register
//   mem_ready       : memory finishes the current access this cycle
//   IorD .. RegWrite: datapath control strobes and selects
//   illegal         : one-cycle pulse while in TRAP
//   state           : current state (debug)
//   retired         : count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int ALU_CTRL_W    = 3,
    parameter bit USE_MEM_READY = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            Funct,
    input  logic                  mem_ready,
    output logic                  IorD,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  Beq,
    output logic                  Bne,
    output logic [1:0]            PCSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  RegDst,
    output logic                  MemToReg,
    output logic                  RegWrite,
    output logic                  illegal,
    output logic [3:0]            state,
    output logic [CNT_W-1:0]      retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // Moore part of the outputs; registered so they are glitch-free.
    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       pcwrite;   // jump only; the FETCH PC load is mem_ready-qualified
        logic       beq;
        logic       bne;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t         state_q, next_state;
    ctrl_t          ctrl_q, next_ctrl;
    logic [CNT_W-1:0] retired_q;
    logic           mem_ok;
    logic           funct_legal;
    logic [2:0]     funct_alu;
    logic           fetch_go;
    logic           retire;

    assign mem_ok = USE_MEM_READY ? mem_ready : 1'b1;

    // R-type funct decode.
    // NOTE: every variable written in an always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op,
                                          input logic [2:0] r_alu);
        ctrl_t c;
        c        = '0;
        c.aluctl = ALU_ADD;
        case (s)
            S_FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
            S_MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            S_MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
            S_EXEC:   begin c.alusrca = 1'b1; c.aluctl = r_alu; end
            S_ALUWB:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluctl  = ALU_SUB;
                c.pcsrc   = 2'b01;
                c.beq     = (op == OP_BEQ);
                c.bne     = (op == OP_BNE);
            end
            S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB: c.regwrite = 1'b1;
            S_JUMP:   begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
            S_TRAP:   c.illegal = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_FETCH:  if (mem_ok) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_RTYPE:       next_state = funct_legal ? S_EXEC : S_TRAP;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:        next_state = S_ADDIEX;
                    OP_J:           next_state = S_JUMP;
                    default:        next_state = S_TRAP;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ok) next_state = S_MEMWB;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  if (mem_ok) next_state = S_FETCH;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_TRAP:   next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Outputs are decoded from the state being entered and registered with it,
    // so the register always holds the Moore outputs of state_q. opcode/Funct
    // are already stable when DECODE picks EXEC or BRANCH.
    assign next_ctrl = decode_ctrl(next_state, opcode, funct_alu);

    // TRAP and unused encodings fall outside this list, so they never count.
    assign retire = (next_state == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode_ctrl(S_FETCH, opcode, funct_alu);
            retired_q <= '0;
        end else begin
            state_q <= next_state;
            ctrl_q  <= next_ctrl;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // FETCH loads IR and PC only once memory has delivered the instruction.
    assign fetch_go = (state_q == S_FETCH) && mem_ok;

    assign IorD       = ctrl_q.iord;
    assign MemRead    = ctrl_q.memread;
    assign MemWrite   = ctrl_q.memwrite;
    assign IRWrite    = fetch_go;
    assign PCWrite    = fetch_go | ctrl_q.pcwrite;
    assign Beq        = ctrl_q.beq;
    assign Bne        = ctrl_q.bne;
    assign PCSrc      = ctrl_q.pcsrc;
    assign ALUSrcA    = ctrl_q.alusrca;
    assign ALUSrcB    = ctrl_q.alusrcb;
    assign ALUControl = ALU_CTRL_W'(ctrl_q.aluctl);
    assign RegDst     = ctrl_q.regdst;
    assign MemToReg   = ctrl_q.memtoreg;
    assign RegWrite   = ctrl_q.regwrite;
    assign illegal    = ctrl_q.illegal;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Three instances share the instruction inputs: default parameters, CNT_W=2,
// and USE_MEM_READY=0 with mem_ready tied low. Stimulus pushes the expected
// state/outputs/retired for each cycle into a queue; a monitor pops one entry
// per cycle of the selected instance and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam logic [3:0] FETCH = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6, ALUWB = 4'd7,
                           BRANCH = 4'd8, ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP = 4'd11,
                           TRAP  = 4'd12;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       beq;
        logic       bne;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]  st;
        ctrl_t       c;
        logic [31:0] ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    int         sel;

    logic       iord_s[3], memread_s[3], memwrite_s[3], irwrite_s[3], pcwrite_s[3];
    logic       beq_s[3], bne_s[3], alusrca_s[3], regdst_s[3], memtoreg_s[3];
    logic       regwrite_s[3], illegal_s[3];
    logic [1:0] pcsrc_s[3], alusrcb_s[3];
    logic [2:0] aluc_s[3];
    logic [3:0] state_s[3];
    logic [31:0] ret0, ret2;
    logic [1:0]  ret1;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Funct(funct), .mem_ready(mem_ready),
        .IorD(iord_s[0]), .MemRead(memread_s[0]), .MemWrite(memwrite_s[0]),
        .IRWrite(irwrite_s[0]), .PCWrite(pcwrite_s[0]), .Beq(beq_s[0]), .Bne(bne_s[0]),
        .PCSrc(pcsrc_s[0]), .ALUSrcA(alusrca_s[0]), .ALUSrcB(alusrcb_s[0]),
        .ALUControl(aluc_s[0]), .RegDst(regdst_s[0]), .MemToReg(memtoreg_s[0]),
        .RegWrite(regwrite_s[0]), .illegal(illegal_s[0]), .state(state_s[0]),
        .retired(ret0)
    );

    multicycle_control_fsm #(.CNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .opcode(opcode), .Funct(funct), .mem_ready(mem_ready),
        .IorD(iord_s[1]), .MemRead(memread_s[1]), .MemWrite(memwrite_s[1]),
        .IRWrite(irwrite_s[1]), .PCWrite(pcwrite_s[1]), .Beq(beq_s[1]), .Bne(bne_s[1]),
        .PCSrc(pcsrc_s[1]), .ALUSrcA(alusrca_s[1]), .ALUSrcB(alusrcb_s[1]),
        .ALUControl(aluc_s[1]), .RegDst(regdst_s[1]), .MemToReg(memtoreg_s[1]),
        .RegWrite(regwrite_s[1]), .illegal(illegal_s[1]), .state(state_s[1]),
        .retired(ret1)
    );

    multicycle_control_fsm #(.USE_MEM_READY(1'b0)) dut_nohs (
        .clk(clk), .reset(reset), .opcode(opcode), .Funct(funct), .mem_ready(1'b0),
        .IorD(iord_s[2]), .MemRead(memread_s[2]), .MemWrite(memwrite_s[2]),
        .IRWrite(irwrite_s[2]), .PCWrite(pcwrite_s[2]), .Beq(beq_s[2]), .Bne(bne_s[2]),
        .PCSrc(pcsrc_s[2]), .ALUSrcA(alusrca_s[2]), .ALUSrcB(alusrcb_s[2]),
        .ALUControl(aluc_s[2]), .RegDst(regdst_s[2]), .MemToReg(memtoreg_s[2]),
        .RegWrite(regwrite_s[2]), .illegal(illegal_s[2]), .state(state_s[2]),
        .retired(ret2)
    );

    // Outputs of the instance currently under observation.
    ctrl_t       mon_c;
    logic [3:0]  mon_st;
    logic [31:0] mon_ret;

    always_comb begin
        mon_c          = '0;
        mon_c.iord     = iord_s[sel];
        mon_c.memread  = memread_s[sel];
        mon_c.memwrite = memwrite_s[sel];
        mon_c.irwrite  = irwrite_s[sel];
        mon_c.pcwrite  = pcwrite_s[sel];
        mon_c.beq      = beq_s[sel];
        mon_c.bne      = bne_s[sel];
        mon_c.pcsrc    = pcsrc_s[sel];
        mon_c.alusrca  = alusrca_s[sel];
        mon_c.alusrcb  = alusrcb_s[sel];
        mon_c.aluctl   = aluc_s[sel];
        mon_c.regdst   = regdst_s[sel];
        mon_c.memtoreg = memtoreg_s[sel];
        mon_c.regwrite = regwrite_s[sel];
        mon_c.illegal  = illegal_s[sel];
        mon_st         = state_s[sel];
        mon_ret        = (sel == 1) ? {30'd0, ret1} : ((sel == 2) ? ret2 : ret0);
    end

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s (entry %0d): got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Expected outputs per state, straight from the control table.
    function automatic ctrl_t model(input logic [3:0] st, input logic [5:0] op,
                                    input logic [5:0] fn, input logic rdy);
        ctrl_t c;
        c        = '0;
        c.aluctl = 3'b010;
        case (st)
            FETCH:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            MEMRD:  begin c.memread = 1; c.iord = 1; end
            MEMWB:  begin c.regwrite = 1; c.memtoreg = 1; end
            MEMWR:  begin c.memwrite = 1; c.iord = 1; end
            EXEC: begin
                c.alusrca = 1;
                case (fn)
                    6'b100010: c.aluctl = 3'b110;
                    6'b100100: c.aluctl = 3'b000;
                    6'b100101: c.aluctl = 3'b001;
                    6'b101010: c.aluctl = 3'b111;
                    default:   c.aluctl = 3'b010;
                endcase
            end
            ALUWB:  begin c.regwrite = 1; c.regdst = 1; end
            BRANCH: begin
                c.alusrca = 1; c.aluctl = 3'b110; c.pcsrc = 2'b01;
                c.beq = (op == 6'b000100); c.bne = (op == 6'b000101);
            end
            ADDIEX: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            ADDIWB: c.regwrite = 1;
            JUMP:   begin c.pcwrite = 1; c.pcsrc = 2'b10; end
            TRAP:   c.illegal = 1;
            default: ;
        endcase
        return c;
    endfunction

    // One cycle of stimulus: drive mem_ready, queue what this cycle must show.
    task automatic step(input logic [3:0] st, input logic rdy, input logic [31:0] ret);
        exp_t e;
        mem_ready = rdy;
        e.st  = st;
        e.c   = model(st, opcode, funct, rdy);
        e.ret = ret;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the observed instance mid-cycle, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("state",   {28'd0, mon_st}, {28'd0, e.st});
                check("ctrl",    {13'd0, mon_c},  {13'd0, e.c});
                check("retired", mon_ret,         e.ret);
                cyc++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sel       = 0;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        @(posedge clk);
        #1;
        // Reset state: FETCH, retired 0, IRWrite/PCWrite low with mem_ready low.
        step(FETCH, 1'b0, 0);
        reset = 1'b0;

        // R-type or.
        funct = 6'b100101;
        step(FETCH, 1'b1, 0); step(DECODE, 1'b1, 0); step(EXEC, 1'b1, 0); step(ALUWB, 1'b1, 0);

        // lw, 2 wait cycles in FETCH and 3 in MEMRD: 10 cycles.
        opcode = 6'b100011;
        step(FETCH, 1'b0, 1); step(FETCH, 1'b0, 1); step(FETCH, 1'b1, 1);
        step(DECODE, 1'b1, 1); step(MEMADR, 1'b1, 1);
        step(MEMRD, 1'b0, 1); step(MEMRD, 1'b0, 1); step(MEMRD, 1'b0, 1); step(MEMRD, 1'b1, 1);
        step(MEMWB, 1'b1, 1);

        // beq then bne.
        opcode = 6'b000100;
        step(FETCH, 1'b1, 2); step(DECODE, 1'b1, 2); step(BRANCH, 1'b1, 2);
        opcode = 6'b000101;
        step(FETCH, 1'b1, 3); step(DECODE, 1'b1, 3); step(BRANCH, 1'b1, 3);

        // Illegal opcode, then illegal funct; retired stays at 4.
        opcode = 6'b111011;
        step(FETCH, 1'b1, 4); step(DECODE, 1'b1, 4); step(TRAP, 1'b1, 4);
        opcode = 6'b000000;
        funct  = 6'b111111;
        step(FETCH, 1'b1, 4); step(DECODE, 1'b1, 4); step(TRAP, 1'b1, 4);
        step(FETCH, 1'b0, 4);

        // 2-bit counter instance: it has retired 4 mod 4 = 0 so far.
        sel    = 1;
        opcode = 6'b100011;
        step(FETCH, 1'b1, 0); step(DECODE, 1'b1, 0); step(MEMADR, 1'b1, 0);
        step(MEMRD, 1'b1, 0); step(MEMWB, 1'b1, 0);
        step(FETCH, 1'b1, 1); step(DECODE, 1'b1, 1); step(MEMADR, 1'b1, 1);
        step(MEMRD, 1'b0, 1); step(MEMRD, 1'b0, 1);
        // Reset while waiting in MEMRD wins over the wait.
        reset = 1'b1;
        step(MEMRD, 1'b0, 1);
        reset = 1'b0;
        opcode = 6'b000010;
        begin
            logic [31:0] jret[5];
            jret = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                step(FETCH, 1'b1, jret[i]); step(DECODE, 1'b1, jret[i]); step(JUMP, 1'b1, jret[i]);
            end
        end
        step(FETCH, 1'b0, 1);

        // No-handshake instance: mem_ready tied low, sw still takes 4 cycles.
        sel   = 2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        opcode = 6'b101011;
        step(FETCH, 1'b1, 0); step(DECODE, 1'b1, 0); step(MEMADR, 1'b1, 0); step(MEMWR, 1'b1, 0);
        step(FETCH, 1'b1, 1);

        // The monitor must have consumed every expectation within a cycle.
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
